// File: rtl/regfile_pkg.sv
// Shared encodings for the SM83 register-file sequencer: ops, register codes,
// FSM states and small decode helpers.
package regfile_pkg;

    typedef enum logic [1:0] {
        OP_MOV8  = 2'd0,
        OP_MOV16 = 2'd1,
        OP_INC16 = 2'd2,
        OP_DEC16 = 2'd3
    } op_e;

    localparam logic [2:0] R_B   = 3'd0;
    localparam logic [2:0] R_C   = 3'd1;
    localparam logic [2:0] R_D   = 3'd2;
    localparam logic [2:0] R_E   = 3'd3;
    localparam logic [2:0] R_H   = 3'd4;
    localparam logic [2:0] R_L   = 3'd5;
    localparam logic [2:0] R_INV = 3'd6;
    localparam logic [2:0] R_A   = 3'd7;

    localparam logic [1:0] RR_BC = 2'd0;
    localparam logic [1:0] RR_DE = 2'd1;
    localparam logic [1:0] RR_HL = 2'd2;
    localparam logic [1:0] RR_SP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_e;

    function automatic logic cmd_legal(input op_e op, input logic [2:0] src,
                                       input logic [2:0] dst);
        logic ok;
        case (op)
            OP_MOV8:  ok = (src != R_INV) && (dst != R_INV);
            OP_MOV16: ok = !dst[2] && !src[2];
            default:  ok = !dst[2];
        endcase
        return ok;
    endfunction

    // B, D and H live in the upper byte of their pair on the LR bus.
    function automatic logic lane_hi(input logic [2:0] code);
        logic hi;
        case (code)
            R_B, R_D, R_H:      hi = 1'b1;
            R_C, R_E, R_L, R_A: hi = 1'b0;
            default:            hi = 1'b0;
        endcase
        return hi;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        logic [7:0] v;
        v = 8'h00;
        if (code != R_INV) v[code] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] onehot16(input logic [1:0] rr);
        logic [3:0] v;
        case (rr)
            RR_BC:   v = 4'b0001;
            RR_DE:   v = 4'b0010;
            RR_HL:   v = 4'b0100;
            RR_SP:   v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/incdec16.sv
// Combinational 16-bit +/-1 for pair increment/decrement; passes the value
// through unchanged for move ops.
module incdec16
    import regfile_pkg::*;
(
    input  logic [15:0] a,
    input  op_e         op,
    output logic [15:0] y
);

    always_comb begin
        case (op)
            OP_INC16: y = a + 16'd1;
            OP_DEC16: y = a - 16'd1;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/regfile_seq.sv
// Register-file transfer sequencer: IDLE -> RD -> WR per accepted command,
// driving per-register strobes and the shared LR bus.
module regfile_seq
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_dst,
    input  logic [2:0]  cmd_src,
    output logic [7:0]  oe8,
    output logic [7:0]  wr8,
    output logic [3:0]  oe16,
    output logic [3:0]  wr16,
    input  logic [15:0] bus_in,
    output logic [15:0] bus_out,
    output logic        bus_oe,
    output logic        done,
    output logic        err
);

    // cmd_valid/cmd_ready: a command transfers on a rising edge where both are
    // high; cmd_* is sampled only on that edge and ignored afterwards.
    state_e      state, state_n;
    op_e         op_q, cmd_op_e;
    logic [2:0]  src_q, dst_q;
    logic [15:0] tmp, step;
    logic [7:0]  oe8_n, wr8_n;
    logic [3:0]  oe16_n, wr16_n;
    logic        bus_oe_n, done_n, err_n;
    logic [7:0]  tmp_byte;

    assign cmd_op_e  = op_e'(cmd_op);
    assign cmd_ready = (state == S_IDLE);

    always_comb begin
        state_n  = state;
        oe8_n    = 8'h00;
        wr8_n    = 8'h00;
        oe16_n   = 4'h0;
        wr16_n   = 4'h0;
        bus_oe_n = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal(cmd_op_e, cmd_src, cmd_dst)) begin
                        state_n = S_RD;
                        case (cmd_op_e)
                            OP_MOV8:  oe8_n  = onehot8(cmd_src);
                            OP_MOV16: oe16_n = onehot16(cmd_src[1:0]);
                            default:  oe16_n = onehot16(cmd_dst[1:0]);
                        endcase
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_RD: begin
                state_n  = S_WR;
                bus_oe_n = 1'b1;
                done_n   = 1'b1;
                if (op_q == OP_MOV8) wr8_n  = onehot8(dst_q);
                else                 wr16_n = onehot16(dst_q[1:0]);
            end
            S_WR:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes are registered one cycle ahead so they align with the state
    // they belong to and never follow cmd_* combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_MOV8;
            src_q  <= 3'd0;
            dst_q  <= 3'd0;
            tmp    <= 16'h0000;
            oe8    <= 8'h00;
            wr8    <= 8'h00;
            oe16   <= 4'h0;
            wr16   <= 4'h0;
            bus_oe <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            oe8    <= oe8_n;
            wr8    <= wr8_n;
            oe16   <= oe16_n;
            wr16   <= wr16_n;
            bus_oe <= bus_oe_n;
            done   <= done_n;
            err    <= err_n;
            if (state == S_IDLE && cmd_valid) begin
                op_q  <= cmd_op_e;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
            end
            if (state == S_RD) tmp <= bus_in;
        end
    end

    incdec16 u_incdec16 (
        .a  (tmp),
        .op (op_q),
        .y  (step)
    );

    assign tmp_byte = lane_hi(src_q) ? tmp[15:8] : tmp[7:0];

    always_comb begin
        bus_out = 16'h0000;
        if (bus_oe) bus_out = (op_q == OP_MOV8) ? {tmp_byte, tmp_byte} : step;
    end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Command-driven sequencer for the SM83 register file. Accepts one register-transfer command at a time over a valid/ready handshake and drives the per-register output-enable/write strobes and the shared 16-bit LR bus for 8-bit moves, 16-bit pair moves and 16-bit increment/decrement. Sits between the instruction decoder and `regfile`. It is the only agent that drives B/C/D/E/H/L/A/SP strobes.

## Interface

- No parameters. All encodings come from `regfile_pkg`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  2  0 MOV8, 1 MOV16, 2 INC16, 3 DEC16.
- `cmd_dst`  in  3  destination code.
  - r8 codes: B=0, C=1, D=2, E=3, H=4, L=5, 6 invalid, A=7.
  - r16 codes in [1:0]: BC=0, DE=1, HL=2, SP=3.
- `cmd_src`  in  3  source code, same encodings; ignored for INC16/DEC16.
- `oe8`  out  8  one-hot read enable indexed by r8 code; bit 6 always 0.
- `wr8`  out  8  one-hot write strobe indexed by r8 code; bit 6 always 0.
- `oe16`  out  4  one-hot pair read enable.
- `wr16`  out  4  one-hot pair write strobe.
- `bus_in`  in  16  LR bus as read from the register file.
- `bus_out`  out  16  value driven onto the LR bus.
- `bus_oe`  out  1  sequencer drives the LR bus.
- `done`  out  1  one-cycle pulse; command completed.
- `err`  out  1  one-cycle pulse; command rejected.

## Operation

- States: IDLE, RD, WR.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`, validate the command and latch op/src/dst.
  - Invalid command: go to IDLE and pulse `err` in the next cycle.
    - MOV8 with src or dst = 6 is invalid.
    - MOV16/INC16/DEC16 with dst[2]=1 is invalid.
    - MOV16 with src[2]=1 is invalid.
  - Valid command: go to RD.
- RD
  - Assert `oe8[src]` (MOV8), `oe16[src]` (MOV16) or `oe16[dst]` (INC16/DEC16).
  - Latch `tmp` (16 bit) from `bus_in` at the cycle end.
  - Byte lane for MOV8: codes 0, 2, 4 take `bus_in[15:8]`; codes 1, 3, 5, 7 take `bus_in[7:0]`.
- WR
  - `bus_oe`=1; assert `wr8[dst]` or `wr16[dst]`; pulse `done`; go to IDLE.
  - MOV8: `bus_out` = {tmp8, tmp8} (byte replicated to both lanes).
  - MOV16: `bus_out` = tmp.
  - INC16: `bus_out` = tmp+1, modulo 2^16.
  - DEC16: `bus_out` = tmp−1, modulo 2^16.
- Src equal to dst is legal and performs the full read/write.
- Outside RD/WR, all strobes and `bus_oe` are 0; `bus_out`=0 when `bus_oe`=0.
- No flags are produced. INC16/DEC16 never touch F.

## Timing

- Accept at edge N (IDLE, `cmd_valid`=1).
- Cycle N+1 is RD; cycle N+2 is WR with `done`=1.
- `cmd_ready` is high again in cycle N+3, so throughput is one command per 3 cycles.
- Rejected command: `err`=1 in cycle N+1 only, `cmd_ready` stays high, and no strobe is asserted.
- Strobes, `done` and `err` are registered outputs decoded from state; they never glitch combinationally from `cmd_*`.
- `cmd_*` is sampled only at the accept edge; later changes are ignored.
- Reset (asynchronous, mid-operation included), effective immediately:
  - state=IDLE, tmp=0.
  - `oe8`=`wr8`=0, `oe16`=`wr16`=0.
  - `bus_oe`=0, `bus_out`=0.
  - `done`=`err`=0.
  - `cmd_ready`=1 while reset is held and after it is released.
- Wrap-around: INC16 of FFFF writes 0000; DEC16 of 0000 writes FFFF.

## Structure

- `regfile_pkg` holds:
  - the op enum (MOV8, MOV16, INC16, DEC16);
  - r8 code constants (R_B..R_A, R_INV=6);
  - r16 code constants (RR_BC..RR_SP);
  - the state enum (S_IDLE, S_RD, S_WR).
- One natural sub-module: `incdec16`, a combinational ±1 on 16 bits that selects on op. Everything else stays in `regfile_seq`.

## Test plan

- MOV8 C←B with B lane `bus_in`=16'hA5xx in RD -> `oe8`=8'h01 in RD; in WR `wr8`=8'h02, `bus_out`=16'hA5A5, `done`=1; `cmd_ready` back at N+3.
- MOV16 HL←SP with `bus_in`=16'h1234 -> `oe16`=4'b1000 in RD; `wr16`=4'b0100, `bus_out`=16'h1234 in WR.
- INC16 BC with `bus_in`=16'hFFFF -> `bus_out`=16'h0000; DEC16 DE with 16'h0000 -> `bus_out`=16'hFFFF, `wr16`=4'b0010.
- MOV8 with src=6 -> `err`=1 at N+1; no strobes; a valid command is accepted at N+1.
- Back-to-back `cmd_valid` held high for 3 commands -> accepts at N, N+3, N+6; exactly 3 `done` pulses.
- Assert `rst` mid-RD of INC16 -> all strobes and `bus_oe` drop in the same cycle; no `done`; `cmd_ready`=1 after release.
